// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the EX stage and the
// iterative multiply/divide unit.
//   start, op, a, b, flush : request from the pipeline (master -> slave)
//   stall_o, busy, done    : status back to hazard control (slave -> master)
//   hi, lo                 : architectural HI/LO registers (slave -> master)
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall_o;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  stall_o, busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall_o, busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit (WIDTH+2 cycles) with
// single-cycle MTHI/MTLO. Owns the HI/LO registers and requests a pipeline
// freeze while a multiply/divide is in flight.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ex_muldiv_if slave (start/op/a/b/flush in; stall_o/busy/done/hi/lo out)
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div0;
    logic [WIDTH-1:0] r_rem;   // mul: upper product half; div: partial remainder
    logic [WIDTH-1:0] r_q;     // mul: multiplier / low product; div: dividend / quotient
    logic [WIDTH-1:0] r_opnd;  // multiplicand or divisor magnitude
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Request decode (only honoured in IDLE and without a flush)
    logic             w_idle;
    logic             w_md_start;
    logic             w_mt_start;
    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_idle     = (r_state == S_IDLE);
    assign w_md_start = bus.start & ~bus.op[2] & ~bus.flush & w_idle;
    assign w_mt_start = bus.start & (bus.op[2:1] == 2'b10) & ~bus.flush & w_idle;
    assign w_signed   = ~bus.op[0];
    assign w_neg_a    = w_signed & bus.a[WIDTH-1];
    assign w_neg_b    = w_signed & bus.b[WIDTH-1];
    assign w_abs_a    = w_neg_a ? WIDTH'(-bus.a) : bus.a;
    assign w_abs_b    = w_neg_b ? WIDTH'(-bus.b) : bus.b;

    // One iteration step: shift-add multiply, restoring shift-subtract divide
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ok;

    assign w_mul_sum   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_opnd} : (WIDTH+1)'(0));
    // Trial remainder needs one extra bit before the subtract
    assign w_div_shift = {r_rem, r_q[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    assign w_div_ok    = ~w_div_diff[WIDTH+1];

    // Sign correction applied on the FIX cycle
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_hi_res;
    logic [WIDTH-1:0] w_lo_res;

    assign w_prod     = {r_rem, r_q};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? PW'(-w_prod) : w_prod;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? WIDTH'(-r_q) : r_q;
    // With a zero divisor the remainder is |a|, so this also restores raw a
    assign w_rem_fix  = r_sign_a ? WIDTH'(-r_rem) : r_rem;
    assign w_hi_res   = r_is_div ? w_rem_fix : w_prod_fix[PW-1:WIDTH];
    assign w_lo_res   = r_is_div ? (r_div0 ? {WIDTH{1'b1}} : w_quo_fix)
                                 : w_prod_fix[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_md_start) w_next_state = S_RUN;
            S_RUN: begin
                if (bus.flush)                    w_next_state = S_IDLE;
                else if (r_cnt == CW'(WIDTH - 1)) w_next_state = S_FIX;
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_rem    <= '0;
            r_q      <= '0;
            r_opnd   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (r_state == S_FIX) & ~bus.flush;
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_cnt    <= '0;
                        r_is_div <= bus.op[1];
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_div0   <= (bus.b == '0);
                        r_rem    <= '0;
                        r_q      <= bus.op[1] ? w_abs_a : w_abs_b;
                        r_opnd   <= bus.op[1] ? w_abs_b : w_abs_a;
                    end
                    if (w_mt_start) begin
                        if (bus.op[0]) r_lo <= bus.a;
                        else           r_hi <= bus.a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_is_div) begin
                        r_rem <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_rem <= w_mul_sum[WIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        r_hi <= w_hi_res;
                        r_lo <= w_lo_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_o = r_busy | w_md_start;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv (mul/div results, signs,
// divide-by-zero, overflow, MTHI/MTLO, flush and asynchronous reset).
module tb_ex_muldiv;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_muldiv_if #(.WIDTH(32)) u_if ();

    ex_muldiv #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one mul/div and follow it until the done pulse ends (bounded)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stall_cycles, output int done_cycles,
                          output logic [31:0] hi_r, output logic [31:0] lo_r,
                          output bit timed_out);
        bit seen;
        stall_cycles = 0;
        done_cycles  = 0;
        hi_r         = '0;
        lo_r         = '0;
        timed_out    = 1'b1;
        seen         = 1'b0;
        @(posedge clk); #1;
        u_if.start = 1'b1;
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (u_if.stall_o) stall_cycles++;
            if (u_if.done) begin
                done_cycles++;
                hi_r = u_if.hi;
                lo_r = u_if.lo;
                seen = 1'b1;
            end else if (seen) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
            u_if.start = 1'b0;
        end
        u_if.start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (u_if.hi !== 32'h0 || u_if.lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h, required 0/0", u_if.hi, u_if.lo);
        end
        n_checks++;
        if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b stall=%b, required 0/0/0",
                     u_if.busy, u_if.done, u_if.stall_o);
        end
    endtask

    task automatic test_multu();
        int st, dn; logic [31:0] h, l; bit to;
        run_op(3'b001, 32'hFFFF_FFFF, 32'd2, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL multu_timeout: done pulse not seen/ended"); end
        n_checks++;
        if (st !== 34) begin n_fail++; $display("FAIL multu_stall: %0d cycles, required 34", st); end
        n_checks++;
        if (dn !== 1) begin n_fail++; $display("FAIL multu_done_len: %0d, required 1", dn); end
        n_checks++;
        if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL multu_result: hi=%h lo=%h, required 00000001/fffffffe", h, l);
        end
    endtask

    task automatic test_signed();
        int st, dn; logic [31:0] h, l; bit to;
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
            n_fail++; $display("FAIL mult_neg: hi=%h lo=%h to=%b, required ffffffff/ffffffeb", h, l, to);
        end
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_neg: hi=%h lo=%h to=%b, required ffffffff/fffffffd", h, l, to);
        end
        n_checks++;
        if (st !== 34) begin n_fail++; $display("FAIL div_stall: %0d cycles, required 34", st); end
        run_op(3'b011, 32'd100, 32'd7, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0 || h !== 32'd2 || l !== 32'd14) begin
            n_fail++; $display("FAIL divu_100_7: hi=%h lo=%h to=%b, required 2/14", h, l, to);
        end
    endtask

    task automatic test_div_corner();
        int st, dn; logic [31:0] h, l; bit to;
        run_op(3'b011, 32'd7, 32'd0, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0 || h !== 32'd7 || l !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL divu_by_zero: hi=%h lo=%h to=%b, required 7/ffffffff", h, l, to);
        end
        n_checks++;
        if (st !== 34) begin n_fail++; $display("FAIL div0_stall: %0d cycles, required 34", st); end
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0 || h !== 32'h0 || l !== 32'h8000_0000) begin
            n_fail++; $display("FAIL div_overflow: hi=%h lo=%h to=%b, required 0/80000000", h, l, to);
        end
    endtask

    task automatic test_mtxx();
        int stall_seen;
        stall_seen = 0;
        @(posedge clk); #1;
        u_if.start = 1'b1; u_if.op = 3'b100; u_if.a = 32'h1234; u_if.b = 32'h0;
        @(negedge clk);
        if (u_if.stall_o) stall_seen++;
        @(posedge clk); #1;
        u_if.op = 3'b101; u_if.a = 32'h5678;
        @(negedge clk);
        if (u_if.stall_o) stall_seen++;
        n_checks++;
        if (u_if.hi !== 32'h1234) begin n_fail++; $display("FAIL mthi: hi=%h, required 00001234", u_if.hi); end
        @(posedge clk); #1;
        u_if.start = 1'b0;
        @(negedge clk);
        if (u_if.stall_o) stall_seen++;
        n_checks++;
        if (u_if.lo !== 32'h5678 || u_if.hi !== 32'h1234) begin
            n_fail++; $display("FAIL mtlo: hi=%h lo=%h, required 00001234/00005678", u_if.hi, u_if.lo);
        end
        n_checks++;
        if (stall_seen !== 0 || u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
            n_fail++; $display("FAIL mtxx_status: stall cycles=%0d busy=%b done=%b, required 0/0/0",
                               stall_seen, u_if.busy, u_if.done);
        end
    endtask

    task automatic test_flush();
        int done_seen;
        done_seen = 0;
        @(posedge clk); #1;
        u_if.start = 1'b1; u_if.op = 3'b011; u_if.a = 32'd100; u_if.b = 32'd7;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: busy=%b, required 1", u_if.busy); end
        u_if.flush = 1'b1;
        @(posedge clk); #1;
        u_if.flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (u_if.stall_o !== 1'b0 || u_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: stall=%b busy=%b, required 0/0", u_if.stall_o, u_if.busy);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_if.done) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) begin n_fail++; $display("FAIL flush_no_done: %0d done cycles, required 0", done_seen); end
        n_checks++;
        if (u_if.hi !== 32'h1234 || u_if.lo !== 32'h5678) begin
            n_fail++; $display("FAIL flush_keep: hi=%h lo=%h, required 00001234/00005678", u_if.hi, u_if.lo);
        end
    endtask

    task automatic test_async_reset();
        int st, dn; logic [31:0] h, l; bit to;
        @(posedge clk); #1;
        u_if.start = 1'b1; u_if.op = 3'b001; u_if.a = 32'd9; u_if.b = 32'd9;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (u_if.hi !== 32'h0 || u_if.lo !== 32'h0 || u_if.busy !== 1'b0 || u_if.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: hi=%h lo=%h busy=%b stall=%b, required 0/0/0/0",
                               u_if.hi, u_if.lo, u_if.busy, u_if.stall_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'b001, 32'd3, 32'd5, st, dn, h, l, to);
        n_checks++;
        if (to !== 1'b0 || h !== 32'h0 || l !== 32'd15) begin
            n_fail++; $display("FAIL post_reset_multu: hi=%h lo=%h to=%b, required 0/15", h, l, to);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        u_if.start = 1'b0;
        u_if.op    = 3'b000;
        u_if.a     = '0;
        u_if.b     = '0;
        u_if.flush = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_multu();
        test_signed();
        test_div_corner();
        test_mtxx();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
